// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter that shares one combinational 8-bit ALU among N_REQ requesters.
// One operation in flight at a time: IDLE (grant) -> EXEC (ALU settles) -> RESP (hold until accepted).
module alu_share_arbiter #(
    parameter int N_REQ = 4,
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_REQ-1:0]   req_valid,
    output logic [N_REQ-1:0]   req_ready,
    input  logic [8*N_REQ-1:0] req_data1,
    input  logic [8*N_REQ-1:0] req_data2,
    input  logic [3*N_REQ-1:0] req_select,
    output logic [7:0]         alu_data1,
    output logic [7:0]         alu_data2,
    output logic [2:0]         alu_select,
    input  logic [7:0]         alu_result,
    input  logic               alu_zero,
    output logic [N_REQ-1:0]   rsp_valid,
    input  logic [N_REQ-1:0]   rsp_ready,
    output logic [7:0]         rsp_result,
    output logic               rsp_zero,
    output logic               rsp_err
);

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] EXEC = 2'b01;
    localparam logic [1:0] RESP = 2'b10;

    logic [1:0]       state_reg;
    logic [PW-1:0]    ptr_reg;
    logic [PW-1:0]    owner_reg;
    logic             err_reg;
    logic [7:0]       alu_data1_reg;
    logic [7:0]       alu_data2_reg;
    logic [2:0]       alu_select_reg;
    logic [N_REQ-1:0] rsp_valid_reg;
    logic [7:0]       rsp_result_reg;
    logic             rsp_zero_reg;
    logic             rsp_err_reg;

    logic [7:0]       data1_arr  [N_REQ];
    logic [7:0]       data2_arr  [N_REQ];
    logic [2:0]       select_arr [N_REQ];

    logic             found;
    logic [PW-1:0]    winner;
    logic             accept;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign data1_arr[gi]  = req_data1[8*gi +: 8];
            assign data2_arr[gi]  = req_data2[8*gi +: 8];
            assign select_arr[gi] = req_select[3*gi +: 3];
        end
    endgenerate

    // Scan starting at the pointer and wrapping, so the last-served requester goes last.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int k = 0; k < N_REQ; k++) begin
            int idx;
            idx = int'(ptr_reg) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                winner = PW'(idx);
            end
        end
    end

    assign req_ready = (state_reg == IDLE && found) ? (N_REQ'(1) << winner) : '0;
    assign accept    = rsp_ready[owner_reg];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            ptr_reg        <= '0;
            owner_reg      <= '0;
            err_reg        <= 1'b0;
            alu_data1_reg  <= 8'h00;
            alu_data2_reg  <= 8'h00;
            alu_select_reg <= 3'b000;
            rsp_valid_reg  <= '0;
            rsp_result_reg <= 8'h00;
            rsp_zero_reg   <= 1'b0;
            rsp_err_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (found) begin
                        alu_data1_reg  <= data1_arr[winner];
                        alu_data2_reg  <= data2_arr[winner];
                        alu_select_reg <= select_arr[winner];
                        owner_reg      <= winner;
                        err_reg        <= select_arr[winner][2];
                        state_reg      <= EXEC;
                    end
                end
                EXEC: begin
                    // Illegal op codes never expose whatever the ALU produced.
                    if (err_reg) begin
                        rsp_result_reg <= 8'h00;
                        rsp_zero_reg   <= 1'b0;
                        rsp_err_reg    <= 1'b1;
                    end else begin
                        rsp_result_reg <= alu_result;
                        rsp_zero_reg   <= alu_zero;
                        rsp_err_reg    <= 1'b0;
                    end
                    rsp_valid_reg <= N_REQ'(1) << owner_reg;
                    state_reg     <= RESP;
                end
                RESP: begin
                    if (accept) begin
                        rsp_valid_reg <= '0;
                        state_reg     <= IDLE;
                        if (owner_reg == PW'(N_REQ - 1)) ptr_reg <= '0;
                        else                            ptr_reg <= owner_reg + 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign alu_data1  = alu_data1_reg;
    assign alu_data2  = alu_data2_reg;
    assign alu_select = alu_select_reg;
    assign rsp_valid  = rsp_valid_reg;
    assign rsp_result = rsp_result_reg;
    assign rsp_zero   = rsp_zero_reg;
    assign rsp_err    = rsp_err_reg;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a stand-in ALU and a response scoreboard.
module tb_alu_share_arbiter;

    localparam int N = 4;
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_FWD = 3'b011;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [8*N-1:0] req_data1;
    logic [8*N-1:0] req_data2;
    logic [3*N-1:0] req_select;
    logic [7:0]     alu_data1;
    logic [7:0]     alu_data2;
    logic [2:0]     alu_select;
    logic [7:0]     alu_result;
    logic           alu_zero;
    logic [N-1:0]   rsp_valid;
    logic [N-1:0]   rsp_ready;
    logic [7:0]     rsp_result;
    logic           rsp_zero;
    logic           rsp_err;

    logic [7:0] d1 [N];
    logic [7:0] d2 [N];
    logic [2:0] sl [N];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        int         idx;
        logic [7:0] result;
        logic       zero;
        logic       err;
        int         gcyc;
    } exp_t;

    exp_t sb [$];
    int   grants [$];
    int   gcycs [$];
    logic prev_rv = 1'b0;

    alu_share_arbiter #(.N_REQ(N)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_data1(req_data1), .req_data2(req_data2), .req_select(req_select),
        .alu_data1(alu_data1), .alu_data2(alu_data2), .alu_select(alu_select),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_data1[8*i +: 8]  = d1[i];
            req_data2[8*i +: 8]  = d2[i];
            req_select[3*i +: 3] = sl[i];
        end
    end

    // Stand-in ALU; illegal codes return deliberate garbage so leakage is visible.
    always_comb begin
        case (alu_select)
            OP_ADD:  alu_result = alu_data1 + alu_data2;
            OP_SUB:  alu_result = alu_data1 - alu_data2;
            OP_AND:  alu_result = alu_data1 & alu_data2;
            OP_FWD:  alu_result = alu_data2;
            default: alu_result = alu_data1 ^ alu_data2;
        endcase
        alu_zero = alu_select[2] ? 1'b1 : (alu_result == 8'h00);
    end

    function automatic exp_t expect_for(input int i, input int gc);
        exp_t e;
        e.idx  = i;
        e.gcyc = gc;
        e.err  = sl[i][2];
        case (sl[i])
            OP_ADD:  e.result = d1[i] + d2[i];
            OP_SUB:  e.result = d1[i] - d2[i];
            OP_AND:  e.result = d1[i] & d2[i];
            OP_FWD:  e.result = d2[i];
            default: e.result = 8'h00;
        endcase
        e.zero = e.err ? 1'b0 : (e.result == 8'h00);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Grant/response monitor feeding and draining the scoreboard.
    always @(negedge clk) begin
        if (reset) begin
            prev_rv <= 1'b0;
        end else begin
            if (req_ready != '0) begin
                int gi = 0;
                for (int i = 0; i < N; i++) if (req_ready[i]) gi = i;
                sb.push_back(expect_for(gi, cyc));
                grants.push_back(gi);
                gcycs.push_back(cyc);
            end
            if (rsp_valid != '0) begin
                if (sb.size() == 0) begin
                    chk("rsp_unexpected", {28'd0, rsp_valid}, 32'd0);
                end else begin
                    if (!prev_rv) chk("latency", cyc, sb[0].gcyc + 2);
                    chk("rsp_valid", {28'd0, rsp_valid}, 32'd1 << sb[0].idx);
                    chk("rsp_result", {24'd0, rsp_result}, {24'd0, sb[0].result});
                    chk("rsp_zero", {31'd0, rsp_zero}, {31'd0, sb[0].zero});
                    chk("rsp_err", {31'd0, rsp_err}, {31'd0, sb[0].err});
                    if ((rsp_valid & rsp_ready) != '0) begin
                        $display("rsp req%0d result=%h zero=%b err=%b",
                                 sb[0].idx, rsp_result, rsp_zero, rsp_err);
                        void'(sb.pop_front());
                    end
                end
            end
            prev_rv <= |rsp_valid;
        end
    end

    task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b, input logic [2:0] s);
        d1[i] = a;
        d2[i] = b;
        sl[i] = s;
    endtask

    task automatic wait_grant(input int i);
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (req_ready != '0) break;
        end
        chk($sformatf("grant_req%0d", i), {28'd0, req_ready}, 32'd1 << i);
        @(posedge clk); #1;
        req_valid[i] = 1'b0;
    endtask

    task automatic wait_rsp();
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (rsp_valid != '0) break;
        end
        chk("rsp_seen", {31'd0, rsp_valid != '0}, 32'd1);
    endtask

    task automatic wait_done();
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (sb.size() == 0) break;
        end
        chk("drain", sb.size(), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] held;
        reset = 1'b1;
        req_valid = '0;
        rsp_ready = '0;
        for (int i = 0; i < N; i++) set_op(i, 8'h00, 8'h00, 3'b000);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", {28'd0, req_ready}, 32'd0);
        chk("rst_rsp_valid", {28'd0, rsp_valid}, 32'd0);
        chk("rst_alu", {13'd0, alu_data1, alu_data2, alu_select}, 32'd0);
        chk("rst_rsp", {22'd0, rsp_result, rsp_zero, rsp_err}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Single ADD from req0: grant in cycle 0, response 2 cycles later.
        @(posedge clk); #1;
        rsp_ready = 4'b1111;
        set_op(0, 8'h05, 8'h03, OP_ADD);
        req_valid = 4'b0001;
        wait_grant(0);
        wait_done();

        // Zero flag from req2.
        @(posedge clk); #1;
        set_op(2, 8'hF0, 8'h0F, OP_AND);
        req_valid = 4'b0100;
        wait_grant(2);
        wait_done();

        // Illegal op from req3; pointer wraps to 0 afterwards.
        @(posedge clk); #1;
        set_op(3, 8'h12, 8'h34, 3'b101);
        req_valid = 4'b1000;
        wait_grant(3);
        wait_done();

        // Fairness: all requesters valid, order 0,1,2,3,0 spaced 3 cycles.
        @(posedge clk); #1;
        for (int i = 0; i < N; i++) set_op(i, 8'h10 + 8'(i), 8'hAA, OP_FWD);
        grants.delete();
        gcycs.delete();
        req_valid = 4'b1111;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (grants.size() >= 5) break;
        end
        @(posedge clk); #1;
        req_valid = '0;
        chk("fair_count", {31'd0, grants.size() >= 5}, 32'd1);
        for (int k = 0; k < 5; k++) begin
            if (k < grants.size()) begin
                chk($sformatf("fair_order%0d", k), grants[k], k % 4);
                if (k > 0) chk($sformatf("fair_gap%0d", k), gcycs[k] - gcycs[k-1], 32'd3);
            end
        end
        wait_done();

        // Backpressure on req1 while req0/req2 wait.
        @(posedge clk); #1;
        set_op(0, 8'h01, 8'h01, OP_ADD);
        set_op(1, 8'h10, 8'h03, OP_SUB);
        set_op(2, 8'h0C, 8'h0A, OP_AND);
        rsp_ready = 4'b1101;
        req_valid = 4'b0111;
        wait_grant(1);
        wait_rsp();
        held = rsp_result;
        for (int n = 0; n < 5; n++) begin
            chk("bp_req_ready", {28'd0, req_ready}, 32'd0);
            chk("bp_rsp_valid", {28'd0, rsp_valid}, 32'b0010);
            chk("bp_hold", {24'd0, rsp_result}, {24'd0, held});
            @(posedge clk); @(negedge clk);
        end
        @(posedge clk); #1;
        rsp_ready = 4'b1111;
        @(posedge clk);
        @(negedge clk);
        chk("bp_release_idle", {28'd0, rsp_valid}, 32'd0);
        chk("bp_next_grant", {28'd0, req_ready}, 32'b0100);
        @(posedge clk); #1;
        req_valid = '0;
        wait_done();

        // Reset during RESP drops the op and returns the pointer to 0.
        @(posedge clk); #1;
        set_op(2, 8'h21, 8'h12, OP_ADD);
        set_op(1, 8'h40, 8'h02, OP_SUB);
        set_op(3, 8'h07, 8'h07, OP_ADD);
        rsp_ready = 4'b0000;
        req_valid = 4'b0100;
        wait_grant(2);
        req_valid = 4'b1010;
        wait_rsp();
        @(posedge clk); #1;
        reset = 1'b1;
        sb.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rr_rsp_valid", {28'd0, rsp_valid}, 32'd0);
        chk("rr_alu", {13'd0, alu_data1, alu_data2, alu_select}, 32'd0);
        chk("rr_rsp", {22'd0, rsp_result, rsp_zero, rsp_err}, 32'd0);
        chk("rr_grant_req1", {28'd0, req_ready}, 32'b0010);
        @(posedge clk); #1;
        req_valid = '0;
        rsp_ready = 4'b1111;
        wait_done();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
